// File: rtl/inst_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue_pkg
// Brief    : Shared bus widths and reset-vector default for the fetch front-end
// Revision : 1.0 - initial release
// ============================================================================
package inst_prefetch_queue_pkg;

  // Instruction address / instruction bus widths used across the SoC
  localparam int c_inst_addr_w = 32;
  localparam int c_inst_data_w = 32;

  // Boot vector: first fetch address after reset
  localparam logic [c_inst_addr_w-1:0] c_reset_pc = 32'h1c00_0000;

  // Byte distance between consecutive instructions of a given width
  function automatic int pc_step(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_prefetch_queue_inst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inst_fifo
// Brief    : Synchronous FIFO holding {instruction, pc} entries, with flush
// Revision : 1.0 - initial release
// ============================================================================
module inst_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_pop;
  logic               w_do_push;

  // Pop only from a non-empty queue; clear overrides both directions
  assign w_do_pop  = i_pop && (r_count != '0) && !i_clear;
  assign w_do_push = i_push && !i_clear;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH (not a power of 2)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; zeroed on reset so the head reads 0 out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Credit accounting upstream makes a push into a full, non-popping queue impossible
  always_ff @(posedge clk) begin
    if (rst && w_do_push && !w_do_pop) begin
      assert (r_count < c_cnt_w'(DEPTH));
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue
// Brief    : Sequential instruction prefetcher with latency-tolerant ROM
//            interface, credit-based issue and epoch-based redirect flush
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = c_inst_addr_w,
  parameter int                DATA_W   = c_inst_data_w,
  parameter int                DEPTH    = 4,
  parameter int                ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_reset_pc)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       inst_valid_o,
  input  logic                       inst_ready_i,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_pc_o,
  output logic                       rom_ce_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic [DATA_W-1:0]          rom_data_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_sum_w = $clog2(DEPTH + ROM_LAT + 1) + 1;
  localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(pc_step(DATA_W));

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_epoch;
  logic               r_pipe_vld [ROM_LAT];
  logic               r_pipe_ep  [ROM_LAT];
  logic [ADDR_W-1:0]  r_pipe_pc  [ROM_LAT];
  logic               w_in_vld   [ROM_LAT];
  logic               w_in_ep    [ROM_LAT];
  logic [ADDR_W-1:0]  w_in_pc    [ROM_LAT];

  logic [c_cnt_w-1:0] w_count;
  logic [c_sum_w-1:0] w_inflight;
  logic [c_sum_w-1:0] w_credit_used;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [DATA_W+ADDR_W-1:0] w_head;

  // Count requests still travelling through the ROM latency pipe
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) w_inflight = w_inflight + c_sum_w'(r_pipe_vld[i]);
  end

  // Issue only when every outstanding request is guaranteed a queue slot
  assign w_credit_used = c_sum_w'(w_count) + w_inflight;
  assign w_issue       = !redirect_i && (w_credit_used < c_sum_w'(DEPTH));

  // rst gates the strobe so it drops the moment reset asserts
  assign rom_ce_o   = w_issue && rst;
  assign rom_addr_o = r_fetch_pc;

  // Oldest pipe stage lines up with rom_data_i; drop it if issued in an older epoch
  assign w_push = r_pipe_vld[ROM_LAT-1] && (r_pipe_ep[ROM_LAT-1] == r_epoch) && !redirect_i;
  assign w_pop  = inst_valid_o && inst_ready_i && !redirect_i;

  // Stage inputs: stage 0 takes the new request, later stages shift from the previous one
  for (genvar g = 0; g < ROM_LAT; g++) begin : g_pipe
    if (g == 0) begin : g_head
      assign w_in_vld[g] = w_issue;
      assign w_in_ep[g]  = r_epoch;
      assign w_in_pc[g]  = r_fetch_pc;
    end else begin : g_body
      assign w_in_vld[g] = r_pipe_vld[g-1];
      assign w_in_ep[g]  = r_pipe_ep[g-1];
      assign w_in_pc[g]  = r_pipe_pc[g-1];
    end
  end

  // In-flight pipe; a redirect also kills every stage so a 1-bit epoch never aliases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_ep[i]  <= 1'b0;
        r_pipe_pc[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pipe_vld[i] <= w_in_vld[i] && !redirect_i;
        r_pipe_ep[i]  <= w_in_ep[i];
        r_pipe_pc[i]  <= w_in_pc[i];
      end
    end
  end

  // Fetch PC and epoch: redirect restarts the stream, otherwise advance per issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_epoch    <= 1'b0;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i;
      r_epoch    <= ~r_epoch;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + c_pc_step;
    end
  end

  inst_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({rom_data_i, r_pipe_pc[ROM_LAT-1]}),
    .i_pop   (w_pop),
    .i_clear (redirect_i),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign inst_valid_o = (w_count != '0);
  assign inst_o       = w_head[DATA_W+ADDR_W-1:ADDR_W];
  assign inst_pc_o    = w_head[ADDR_W-1:0];
  assign occupancy_o  = w_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch_queue
// Brief    : Self-checking bench; two instances (ROM_LAT=1 and ROM_LAT=2)
//            driven with the same stimulus, checked against a PC-stream model
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_queue;

  localparam logic [31:0] c_reset_pc = 32'h1c00_0000;

  typedef struct packed {
    logic        mark;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b0;

  logic        v1, v2, ce1, ce2;
  logic [31:0] inst1, inst2, pc1, pc2, addr1, addr2;
  logic [31:0] rom_data1 = 32'h0;
  logic [31:0] rom_data2 = 32'h0;
  logic [2:0]  occ1, occ2;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t log1[$];
  ent_t log2[$];
  logic [32:0] hist1[$];
  logic [32:0] hist2[$];
  int   max_occ1 = 0;
  int   max_occ2 = 0;

  always #5 clk = ~clk;

  inst_prefetch_queue #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .ROM_LAT(1), .RESET_PC(c_reset_pc)
  ) dut1 (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc),
    .inst_valid_o(v1), .inst_ready_i(ready), .inst_o(inst1), .inst_pc_o(pc1),
    .rom_ce_o(ce1), .rom_addr_o(addr1), .rom_data_i(rom_data1), .occupancy_o(occ1)
  );

  inst_prefetch_queue #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .ROM_LAT(2), .RESET_PC(c_reset_pc)
  ) dut2 (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc),
    .inst_valid_o(v2), .inst_ready_i(ready), .inst_o(inst2), .inst_pc_o(pc2),
    .rom_ce_o(ce2), .rom_addr_o(addr2), .rom_data_i(rom_data2), .occupancy_o(occ2)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ROM model: data for a request appears ROM_LAT cycles later; garbage otherwise
  always @(negedge clk) begin
    logic [32:0] h;
    hist1.push_front({ce1, addr1});
    hist2.push_front({ce2, addr2});
    if (hist1.size() > 4) void'(hist1.pop_back());
    if (hist2.size() > 4) void'(hist2.pop_back());
    rom_data1 = $urandom;
    rom_data2 = $urandom;
    if (hist1.size() > 1) begin
      h = hist1[1];
      if (h[32]) rom_data1 = rom_word(h[31:0]);
    end
    if (hist2.size() > 2) begin
      h = hist2[2];
      if (h[32]) rom_data2 = rom_word(h[31:0]);
    end
  end

  // Record the stream seen by the core: restarts (reset/redirect) and accepted instructions
  always @(negedge clk) begin
    if (!rst) begin
      log1.push_back('{1'b1, c_reset_pc, 32'h0});
      log2.push_back('{1'b1, c_reset_pc, 32'h0});
    end else if (redirect_i) begin
      log1.push_back('{1'b1, redirect_pc, 32'h0});
      log2.push_back('{1'b1, redirect_pc, 32'h0});
    end else begin
      if (v1 && ready) log1.push_back('{1'b0, pc1, inst1});
      if (v2 && ready) log2.push_back('{1'b0, pc2, inst2});
    end
    if (int'(occ1) > max_occ1) max_occ1 = int'(occ1);
    if (int'(occ2) > max_occ2) max_occ2 = int'(occ2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (ce1 !== 1'b0 || ce2 !== 1'b0) begin n_errors++; $display("FAIL reset_ce: got %b/%b expected 0/0", ce1, ce2); end
    n_checks++; if (addr1 !== c_reset_pc) begin n_errors++; $display("FAIL reset_addr: got %h expected %h", addr1, c_reset_pc); end
    n_checks++; if (v1 !== 1'b0 || v2 !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b/%b expected 0/0", v1, v2); end
    n_checks++; if (inst1 !== 32'h0 || pc1 !== 32'h0) begin n_errors++; $display("FAIL reset_head: got inst=%h pc=%h expected 0/0", inst1, pc1); end
    n_checks++; if (occ1 !== 3'd0 || occ2 !== 3'd0) begin n_errors++; $display("FAIL reset_occ: got %0d/%0d expected 0/0", occ1, occ2); end
  endtask

  task automatic test_stream();
    ready = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (ce1 !== 1'b1 || addr1 !== c_reset_pc + 32'(i * 4)) begin n_errors++; $display("FAIL stream_addr1[%0d]: got ce=%b addr=%h expected 1 %h", i, ce1, addr1, c_reset_pc + 32'(i * 4)); end
      n_checks++; if (ce2 !== 1'b1 || addr2 !== c_reset_pc + 32'(i * 4)) begin n_errors++; $display("FAIL stream_addr2[%0d]: got ce=%b addr=%h expected 1 %h", i, ce2, addr2, c_reset_pc + 32'(i * 4)); end
      n_checks++; if (v1 !== (i >= 2)) begin n_errors++; $display("FAIL stream_valid1[%0d]: got %b expected %b", i, v1, (i >= 2)); end
      n_checks++; if (v2 !== (i >= 3)) begin n_errors++; $display("FAIL stream_valid2[%0d]: got %b expected %b", i, v2, (i >= 3)); end
      if (i == 2) begin
        n_checks++; if (pc1 !== c_reset_pc) begin n_errors++; $display("FAIL first_pc1: got %h expected %h", pc1, c_reset_pc); end
      end
      if (i == 3) begin
        n_checks++; if (pc2 !== c_reset_pc) begin n_errors++; $display("FAIL first_pc2: got %h expected %h", pc2, c_reset_pc); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    n_checks++; if (occ1 !== 3'd4 || occ2 !== 3'd4) begin n_errors++; $display("FAIL bp_occ: got %0d/%0d expected 4/4", occ1, occ2); end
    n_checks++; if (ce1 !== 1'b0 || ce2 !== 1'b0) begin n_errors++; $display("FAIL bp_ce: got %b/%b expected 0/0", ce1, ce2); end
    tick();
    ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_redirect();
    redirect_i  = 1'b1;
    redirect_pc = 32'h1c00_0100;
    @(negedge clk);
    n_checks++; if (v1 !== 1'b1 || v2 !== 1'b1) begin n_errors++; $display("FAIL redir_head_valid: got %b/%b expected 1/1", v1, v2); end
    n_checks++; if (ce1 !== 1'b0 || ce2 !== 1'b0) begin n_errors++; $display("FAIL redir_ce: got %b/%b expected 0/0", ce1, ce2); end
    tick();
    redirect_i = 1'b0;
    @(negedge clk);
    n_checks++; if (occ1 !== 3'd0 || occ2 !== 3'd0) begin n_errors++; $display("FAIL redir_occ: got %0d/%0d expected 0/0", occ1, occ2); end
    n_checks++; if (ce1 !== 1'b1 || addr1 !== 32'h1c00_0100 || addr2 !== 32'h1c00_0100) begin n_errors++; $display("FAIL redir_addr: got ce=%b %h/%h expected 1 1c000100", ce1, addr1, addr2); end
    tick();
    @(negedge clk);
    n_checks++; if (v1 !== 1'b0 || v2 !== 1'b0) begin n_errors++; $display("FAIL redir_gap: got %b/%b expected 0/0", v1, v2); end
    tick();
    @(negedge clk);
    n_checks++; if (v1 !== 1'b1 || pc1 !== 32'h1c00_0100 || v2 !== 1'b0) begin n_errors++; $display("FAIL redir_first1: got v=%b pc=%h v2=%b expected 1 1c000100 0", v1, pc1, v2); end
    tick();
    @(negedge clk);
    n_checks++; if (v2 !== 1'b1 || pc2 !== 32'h1c00_0100) begin n_errors++; $display("FAIL redir_first2: got v=%b pc=%h expected 1 1c000100", v2, pc2); end
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    int n1, n2;
    redirect_i  = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    n1 = log1.size();
    n2 = log2.size();
    repeat (10) tick();
    n_checks++;
    if (log1.size() < n1 + 2 || log1[n1].pc !== 32'hFFFF_FFFC || log1[n1+1].pc !== 32'h0) begin
      n_errors++; $display("FAIL wrap1: got %0d entries, first pcs %h %h expected fffffffc 00000000", log1.size() - n1, log1[n1].pc, log1[n1+1].pc);
    end
    n_checks++;
    if (log2.size() < n2 + 2 || log2[n2].pc !== 32'hFFFF_FFFC || log2[n2+1].pc !== 32'h0) begin
      n_errors++; $display("FAIL wrap2: got %0d entries, first pcs %h %h expected fffffffc 00000000", log2.size() - n2, log2[n2].pc, log2[n2+1].pc);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (ce1 !== 1'b0 || ce2 !== 1'b0) begin n_errors++; $display("FAIL midrst_ce: got %b/%b expected 0/0", ce1, ce2); end
    n_checks++; if (occ1 !== 3'd0 || v1 !== 1'b0) begin n_errors++; $display("FAIL midrst_occ: got occ=%0d v=%b expected 0 0", occ1, v1); end
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ce1 !== 1'b1 || addr1 !== c_reset_pc || addr2 !== c_reset_pc) begin n_errors++; $display("FAIL midrst_restart: got ce=%b %h/%h expected 1 %h", ce1, addr1, addr2, c_reset_pc); end
    n_checks++; if (occ1 !== 3'd0 || occ2 !== 3'd0) begin n_errors++; $display("FAIL midrst_restart_occ: got %0d/%0d expected 0/0", occ1, occ2); end
    repeat (10) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      ready       = ($urandom_range(0, 3) != 0);
      redirect_i  = ($urandom_range(0, 24) == 0) || (i == 100) || (i == 101);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    redirect_i = 1'b0;
    ready      = 1'b1;
    repeat (20) tick();
  endtask

  // Replay the recorded streams: each restart sets the next PC, each accept must be next in sequence
  task automatic test_scoreboard();
    logic [31:0] exp_pc;
    ent_t        e;
    int          pops;
    exp_pc = c_reset_pc;
    pops   = 0;
    foreach (log1[i]) begin
      e = log1[i];
      if (e.mark) exp_pc = e.pc;
      else begin
        n_checks++; pops++;
        if (e.pc !== exp_pc || e.inst !== rom_word(exp_pc)) begin
          n_errors++; $display("FAIL stream1[%0d]: got pc=%h inst=%h expected pc=%h inst=%h", i, e.pc, e.inst, exp_pc, rom_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    n_checks++; if (pops < 150) begin n_errors++; $display("FAIL progress1: got %0d accepts expected at least 150", pops); end
    exp_pc = c_reset_pc;
    pops   = 0;
    foreach (log2[i]) begin
      e = log2[i];
      if (e.mark) exp_pc = e.pc;
      else begin
        n_checks++; pops++;
        if (e.pc !== exp_pc || e.inst !== rom_word(exp_pc)) begin
          n_errors++; $display("FAIL stream2[%0d]: got pc=%h inst=%h expected pc=%h inst=%h", i, e.pc, e.inst, exp_pc, rom_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    n_checks++; if (pops < 150) begin n_errors++; $display("FAIL progress2: got %0d accepts expected at least 150", pops); end
    n_checks++; if (max_occ1 > 4 || max_occ2 > 4) begin n_errors++; $display("FAIL max_occ: got %0d/%0d expected at most 4", max_occ1, max_occ2); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    test_scoreboard();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
